// File: rtl/pipelined_addsub.sv
// pipelined_addsub
//   Two's-complement adder/subtractor split into STAGES carry-chained slices
//   of CW = WIDTH/STAGES bits, one slice per clock. Stage k adds slice k of
//   the operands using the carry registered by stage k-1 (stage 0 uses the
//   effective carry-in). Lower result slices and the still-unused upper
//   operand slices travel forward with the beat. The last stage also
//   produces the carry out of bit WIDTH-1 and the signed overflow flag.
//
// Handshake (both sides): a beat transfers on a rising edge where valid and
//   ready are both high. The producer holds its beat unchanged while valid is
//   high and ready is low. o_ready = !o_valid || i_ready is the global advance
//   enable; it never depends on i_valid.
//
// Ports
//   i_clk, i_rst    clock, asynchronous active-high reset
//   i_valid/o_ready upstream handshake
//   i_A, i_B        operands
//   i_carry         carry-in (add mode only)
//   i_sub           0 = A + B + i_carry, 1 = A + ~B + 1
//   o_valid/i_ready downstream handshake
//   o_S             result, modulo 2^WIDTH
//   o_carry         carry out of bit WIDTH-1 (1 = no borrow when subtracting)
//   o_overflow      signed overflow of the result
module pipelined_addsub #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_A,
  input  logic [WIDTH-1:0] i_B,
  input  logic             i_carry,
  input  logic             i_sub,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_S,
  output logic             o_carry,
  output logic             o_overflow
);

  localparam int CW   = WIDTH / STAGES;
  localparam int LAST = STAGES - 1;

  // Per-stage registers: operands (B already conditionally inverted), the
  // partially built sum, the carry out of this stage's slice, and valid.
  logic [WIDTH-1:0]  r_a [STAGES];
  logic [WIDTH-1:0]  r_b [STAGES];
  logic [WIDTH-1:0]  r_s [STAGES];
  logic [STAGES-1:0] r_c;
  logic [STAGES-1:0] r_v;
  logic              r_ovf;

  // Inputs seen by each stage: the upstream beat for stage 0, the previous
  // stage's registers otherwise.
  logic [WIDTH-1:0]  src_a [STAGES];
  logic [WIDTH-1:0]  src_b [STAGES];
  logic [WIDTH-1:0]  src_s [STAGES];
  logic [STAGES-1:0] src_c;
  logic [STAGES-1:0] src_v;

  logic [WIDTH-1:0]  nxt_s [STAGES];
  logic [STAGES-1:0] nxt_c;
  logic [CW:0]       slice_sum [STAGES];
  logic              nxt_ovf;
  logic              en;

  assign en      = !r_v[LAST] || i_ready;
  assign o_ready = en;

  always_comb begin
    src_a[0] = i_A;
    src_b[0] = i_sub ? ~i_B : i_B;
    src_s[0] = '0;
    // Subtract forces the +1 of the two's-complement negation.
    src_c[0] = i_sub | i_carry;
    src_v[0] = i_valid;
    for (int k = 1; k < STAGES; k++) begin
      src_a[k] = r_a[k-1];
      src_b[k] = r_b[k-1];
      src_s[k] = r_s[k-1];
      src_c[k] = r_c[k-1];
      src_v[k] = r_v[k-1];
    end

    for (int k = 0; k < STAGES; k++) begin
      slice_sum[k] = {1'b0, src_a[k][k*CW +: CW]}
                   + {1'b0, src_b[k][k*CW +: CW]}
                   + {{CW{1'b0}}, src_c[k]};
      nxt_s[k]              = src_s[k];
      nxt_s[k][k*CW +: CW]  = slice_sum[k][CW-1:0];
      nxt_c[k]              = slice_sum[k][CW];
    end

    // Carry into the MSB is recovered from the MSB sum bit; overflow is that
    // carry XOR the carry out of the MSB.
    nxt_ovf = (src_a[LAST][WIDTH-1] ^ src_b[LAST][WIDTH-1] ^ nxt_s[LAST][WIDTH-1])
            ^ nxt_c[LAST];
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int k = 0; k < STAGES; k++) begin
        r_a[k] <= '0;
        r_b[k] <= '0;
        r_s[k] <= '0;
      end
      r_c   <= '0;
      r_v   <= '0;
      r_ovf <= 1'b0;
    end else if (en) begin
      r_v <= src_v;
      // Data registers only load under a valid beat so idle outputs keep
      // their last value.
      for (int k = 0; k < STAGES; k++) begin
        if (src_v[k]) begin
          r_a[k] <= src_a[k];
          r_b[k] <= src_b[k];
          r_s[k] <= nxt_s[k];
          r_c[k] <= nxt_c[k];
        end
      end
      if (src_v[LAST]) r_ovf <= nxt_ovf;
    end
  end

  assign o_valid    = r_v[LAST];
  assign o_S        = r_s[LAST];
  assign o_carry    = r_c[LAST];
  assign o_overflow = r_ovf;

endmodule

// File: tb/tb_pipelined_addsub.sv
module tb_pipelined_addsub;
  localparam int W = 16;
  localparam int S = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // ---------------- main DUT ----------------
  logic         i_valid = 1'b0, i_ready = 1'b1, i_carry = 1'b0, i_sub = 1'b0;
  logic [W-1:0] i_a = '0, i_b = '0;
  logic         o_ready, o_valid, o_carry, o_overflow;
  logic [W-1:0] o_s;

  pipelined_addsub #(.WIDTH(W), .STAGES(S)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_A(i_a), .i_B(i_b), .i_carry(i_carry), .i_sub(i_sub),
    .o_valid(o_valid), .i_ready(i_ready), .o_S(o_s),
    .o_carry(o_carry), .o_overflow(o_overflow)
  );

  // ---------------- parameter sweep DUTs ----------------
  logic         sw_valid = 1'b0, sw_cin = 1'b0, sw_sub = 1'b0, sw_rdy = 1'b1;
  logic [15:0]  sw_a = '0, sw_b = '0;
  logic [31:0]  w_a = '0, w_b = '0;
  logic         s1_rdy, s1_v, s1_c, s1_o;
  logic [15:0]  s1_s;
  logic         s16_rdy, s16_v, s16_c, s16_o;
  logic [15:0]  s16_s;
  logic         w_rdy, w_v, w_c, w_o;
  logic [31:0]  w_s;

  pipelined_addsub #(.WIDTH(16), .STAGES(1)) u_s1 (
    .i_clk(clk), .i_rst(rst), .i_valid(sw_valid), .o_ready(s1_rdy),
    .i_A(sw_a), .i_B(sw_b), .i_carry(sw_cin), .i_sub(sw_sub),
    .o_valid(s1_v), .i_ready(sw_rdy), .o_S(s1_s), .o_carry(s1_c), .o_overflow(s1_o)
  );
  pipelined_addsub #(.WIDTH(16), .STAGES(16)) u_s16 (
    .i_clk(clk), .i_rst(rst), .i_valid(sw_valid), .o_ready(s16_rdy),
    .i_A(sw_a), .i_B(sw_b), .i_carry(sw_cin), .i_sub(sw_sub),
    .o_valid(s16_v), .i_ready(sw_rdy), .o_S(s16_s), .o_carry(s16_c), .o_overflow(s16_o)
  );
  pipelined_addsub #(.WIDTH(32), .STAGES(8)) u_w32 (
    .i_clk(clk), .i_rst(rst), .i_valid(sw_valid), .o_ready(w_rdy),
    .i_A(w_a), .i_B(w_b), .i_carry(sw_cin), .i_sub(sw_sub),
    .o_valid(w_v), .i_ready(sw_rdy), .o_S(w_s), .o_carry(w_c), .o_overflow(w_o)
  );

  // ---------------- scoreboard state ----------------
  int           n_checks = 0;
  int           n_errors = 0;
  int           cyc = 0;
  int           n_push = 0;
  int           n_pop = 0;
  logic [W+1:0] exp_q[$];       // {overflow, carry, sum}
  int           lat_q[$];
  logic [W+1:0] drv_exp = '0;
  logic [W+1:0] held = '0;
  bit           lat_chk = 1'b0;
  bit           rand_rdy = 1'b0;
  bit           hold_prev = 1'b0;
  bit           last_acc = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: subtract computed as a true difference, carry = no borrow.
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic cin, input logic sub);
    logic [W-1:0] bp;
    logic [W:0]   full;
    logic         c, ovf;
    bp = sub ? ~b : b;
    if (sub) begin
      full = {1'b0, a} - {1'b0, b};
      c    = (a >= b);
    end else begin
      full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
      c    = full[W];
    end
    ovf = (a[W-1] == bp[W-1]) && (full[W-1] != a[W-1]);
    return {ovf, c, full[W-1:0]};
  endfunction

  // One clock: monitor just before the edge, then step past it.
  task automatic cycle();
    logic [W+1:0] e;
    int           l;
    if (rand_rdy) i_ready = 1'($urandom_range(0, 1));
    @(negedge clk);
    check("o_ready", o_ready, !o_valid || i_ready);
    if (hold_prev) check("hold_stable", {o_valid, o_overflow, o_carry, o_s}, {1'b1, held});
    hold_prev = o_valid && !i_ready;
    held      = {o_overflow, o_carry, o_s};
    if (o_valid && i_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_beat: got %0h expected none", {o_overflow, o_carry, o_s});
      end else begin
        e = exp_q.pop_front();
        l = lat_q.pop_front();
        check("result", {o_overflow, o_carry, o_s}, e);
        if (lat_chk) check("latency", cyc - l, S);
        n_pop++;
      end
    end
    last_acc = i_valid && o_ready;
    if (last_acc) begin
      exp_q.push_back(drv_exp);
      lat_q.push_back(cyc);
      n_push++;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // ---------------- driver tasks ----------------
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                      input logic sub, input logic [W+1:0] e);
    int guard = 0;
    i_a = a; i_b = b; i_carry = cin; i_sub = sub; drv_exp = e; i_valid = 1'b1;
    cycle();
    while (!last_acc && guard < 100) begin
      cycle();
      guard++;
    end
    if (!last_acc) check("accept_timeout", last_acc, 1);
  endtask

  task automatic send_rand();
    logic [W-1:0] a, b;
    logic         cin, sub;
    a   = W'($urandom_range(0, 65535));
    b   = W'($urandom_range(0, 65535));
    cin = 1'($urandom_range(0, 1));
    sub = 1'($urandom_range(0, 1));
    send(a, b, cin, sub, model(a, b, cin, sub));
  endtask

  task automatic drain();
    i_valid  = 1'b0;
    rand_rdy = 1'b0;
    i_ready  = 1'b1;
    for (int k = 0; k < 60 && exp_q.size() != 0; k++) cycle();
    check("drain_empty", exp_q.size(), 0);
  endtask

  // ---------------- directed vectors (hand computed) ----------------
  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [17:0] exp;   // {overflow, carry, sum}
  } vec_t;

  vec_t vecs [8] = '{
    '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 18'h1_0000},
    '{16'hFFFF, 16'h0001, 1'b1, 1'b0, 18'h1_0001},
    '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 18'h2_8000},
    '{16'h0005, 16'h0007, 1'b1, 1'b1, 18'h0_FFFE},
    '{16'h8000, 16'h0001, 1'b0, 1'b1, 18'h3_7FFF},
    '{16'h1234, 16'h1111, 1'b0, 1'b0, 18'h0_2345},
    '{16'h0007, 16'h0005, 1'b0, 1'b1, 18'h1_0002},
    '{16'h00FF, 16'h0F01, 1'b1, 1'b0, 18'h0_1001}
  };

  // Sweep corners: 0x..FF + 1, 0 - 1, max positive + 1.
  logic [15:0] swa16 [3] = '{16'hFFFF, 16'h0000, 16'h7FFF};
  logic [15:0] swb16 [3] = '{16'h0001, 16'h0001, 16'h0001};
  logic [31:0] swa32 [3] = '{32'hFFFF_FFFF, 32'h0000_0000, 32'h7FFF_FFFF};
  logic [31:0] swb32 [3] = '{32'h0000_0001, 32'h0000_0001, 32'h0000_0001};
  logic        swsub [3] = '{1'b0, 1'b1, 1'b0};
  logic [17:0] swe16 [3] = '{18'h1_0000, 18'h0_FFFF, 18'h2_8000};
  logic [33:0] swe32 [3] = '{34'h1_0000_0000, 34'h0_FFFF_FFFF, 34'h2_8000_0000};

  task automatic run_sweep();
    bit seen1, seen16, seen32;
    for (int v = 0; v < 3; v++) begin
      sw_a = swa16[v]; sw_b = swb16[v]; w_a = swa32[v]; w_b = swb32[v];
      sw_sub = swsub[v]; sw_cin = 1'b0; sw_valid = 1'b1;
      cycle();
      sw_valid = 1'b0;
      seen1 = 0; seen16 = 0; seen32 = 0;
      for (int k = 1; k <= 40; k++) begin
        if (s1_v && !seen1) begin
          seen1 = 1;
          check("s1_result", {s1_o, s1_c, s1_s}, swe16[v]);
          check("s1_latency", k, 1);
        end
        if (s16_v && !seen16) begin
          seen16 = 1;
          check("s16_result", {s16_o, s16_c, s16_s}, swe16[v]);
          check("s16_latency", k, 16);
        end
        if (w_v && !seen32) begin
          seen32 = 1;
          check("w32_result", {w_o, w_c, w_s}, swe32[v]);
          check("w32_latency", k, 8);
        end
        cycle();
      end
      check("s1_seen", seen1, 1);
      check("s16_seen", seen16, 1);
      check("w32_seen", seen32, 1);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int snap;
    #1 rst = 1'b1;
    #2;
    check("rst_o_valid", o_valid, 0);
    check("rst_o_ready", o_ready, 1);
    check("rst_o_s", o_s, 0);
    check("rst_o_carry", o_carry, 0);
    check("rst_o_overflow", o_overflow, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Directed vectors, back to back.
    lat_chk = 1'b1;
    for (int i = 0; i < 8; i++) send(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, vecs[i].exp);
    drain();

    // Streaming: 100 back-to-back beats, exact latency.
    for (int i = 0; i < 100; i++) send_rand();
    drain();

    // Backpressure with random gaps and random downstream ready.
    lat_chk  = 1'b0;
    rand_rdy = 1'b1;
    for (int i = 0; i < 60; i++) begin
      send_rand();
      if ($urandom_range(0, 2) == 0) begin
        i_valid = 1'b0;
        cycle();
      end
    end
    drain();
    check("push_pop_count", n_pop, n_push);

    // Reset with beats in flight and one at the output.
    i_ready = 1'b1;
    for (int i = 0; i < 5; i++) send_rand();
    i_valid = 1'b0;
    check("pre_rst_valid", o_valid, 1);
    rst = 1'b1;
    #1;
    check("midrst_o_valid", o_valid, 0);
    check("midrst_o_s", o_s, 0);
    check("midrst_o_carry", o_carry, 0);
    check("midrst_o_overflow", o_overflow, 0);
    check("midrst_o_ready", o_ready, 1);
    exp_q.delete();
    lat_q.delete();
    hold_prev = 1'b0;
    cycle();
    rst = 1'b0;
    snap    = n_pop;
    lat_chk = 1'b1;
    send(16'h1234, 16'h1111, 1'b0, 1'b0, 18'h0_2345);
    i_valid = 1'b0;
    for (int k = 0; k < 12; k++) cycle();
    check("post_rst_beats", n_pop - snap, 1);
    check("post_rst_empty", exp_q.size(), 0);
    lat_chk = 1'b0;

    run_sweep();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
